zapper_input_arb: RTL and testbench

ZAPPER_INPUT_ARB -- requirements
Module: zapper_input_arb

---
 rtl/zapper_input_arb.sv | 168 ++++++++++++++++
 tb/tb_zapper_input_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zapper_input_arb.sv
// Zapper input arbiter: chooses whether the PS/2 mouse or the analog stick
// drives the lightgun position and trigger, hands ownership over after the
// owner has been idle for HOLD_FRAMES frames, and suppresses the trigger for
// GUARD_FRAMES frames while the source changes.
// Optional feature macro: ZAPPER_ARB_RELEASE_EN -- after entering JOY the
// trigger stays low until joy_btn has been seen released at least once.
module zapper_input_arb #(
    parameter int DEADZONE     = 16,
    parameter int HOLD_FRAMES  = 60,
    parameter int GUARD_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [24:0] ps2_mouse,
    input  logic [15:0] analog,
    input  logic        joy_btn,
    input  logic        frame_tick,
    input  logic [1:0]  force_src,
    output logic        mode,
    output logic        trigger_mode,
    output logic        analog_trigger,
    output logic [1:0]  state,
    output logic        switch_pulse
);

    typedef enum logic [1:0] {
        ST_MOUSE = 2'b00,
        ST_JOY   = 2'b01,
        ST_GUARD = 2'b10
    } arb_state_t;

    localparam int IDLE_W  = (HOLD_FRAMES  < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam int GUARD_W = (GUARD_FRAMES < 1) ? 1 : $clog2(GUARD_FRAMES + 1);
    localparam logic [IDLE_W-1:0]  HOLD_MAX  = IDLE_W'(HOLD_FRAMES);
    localparam logic [GUARD_W-1:0] GUARD_MAX = GUARD_W'(GUARD_FRAMES);
    localparam logic [8:0]         DEAD_MAG  = 9'(DEADZONE);

    arb_state_t         state_q, state_d;
    logic               target_q, target_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;
    logic               mouse_tog_q, mouse_tog_d;
    logic               mode_q, mode_d;
    logic               trigger_mode_q, trigger_mode_d;
    logic               analog_trigger_q, analog_trigger_d;
    logic               switch_pulse_q, switch_pulse_d;
`ifdef ZAPPER_ARB_RELEASE_EN
    logic               release_ok_q, release_ok_d;
`endif

    logic [8:0] x_ext, y_ext, x_mag, y_mag;
    logic       mouse_act, joy_act;
    logic       owner_joy, owner_act, other_act;
    logic       force_valid, force_joy;
    logic       unused_mouse_bits;

    // Mouse packet bits [7:1] carry nothing the arbiter needs.
    assign unused_mouse_bits = ^ps2_mouse[7:1];

    // Stick magnitudes use 9 bits so that -128 becomes +128 rather than wrapping.
    assign x_ext = {analog[7], analog[7:0]};
    assign y_ext = {analog[15], analog[15:8]};
    assign x_mag = x_ext[8] ? (~x_ext + 9'd1) : x_ext;
    assign y_mag = y_ext[8] ? (~y_ext + 9'd1) : y_ext;

    assign mouse_act = (ps2_mouse[24] != mouse_tog_q) &&
                       ((ps2_mouse[15:8] != 8'd0) || (ps2_mouse[23:16] != 8'd0) || ps2_mouse[0]);
    assign joy_act   = (x_mag > DEAD_MAG) || (y_mag > DEAD_MAG) || joy_btn;

    assign owner_joy   = (state_q == ST_JOY);
    assign owner_act   = owner_joy ? joy_act : mouse_act;
    assign other_act   = owner_joy ? mouse_act : joy_act;
    assign force_valid = (force_src == 2'b01) || (force_src == 2'b10);
    assign force_joy   = (force_src == 2'b10);

    // Next-state logic: ownership decisions, counters and the registered outputs that follow the next state.
    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        idle_cnt_d     = idle_cnt_q;
        guard_cnt_d    = guard_cnt_q;
        mouse_tog_d    = ps2_mouse[24];
        switch_pulse_d = 1'b0;

        case (state_q)
            ST_MOUSE, ST_JOY: begin
                if (force_valid && (force_joy != owner_joy)) begin
                    state_d        = ST_GUARD;
                    target_d       = force_joy;
                    guard_cnt_d    = '0;
                    idle_cnt_d     = '0;
                    switch_pulse_d = 1'b1;
                end else if (!force_valid && other_act && !owner_act && (idle_cnt_q == HOLD_MAX)) begin
                    state_d        = ST_GUARD;
                    target_d       = !owner_joy;
                    guard_cnt_d    = '0;
                    idle_cnt_d     = '0;
                    switch_pulse_d = 1'b1;
                end else if (owner_act) begin
                    idle_cnt_d = '0;
                end else if (frame_tick && (idle_cnt_q != HOLD_MAX)) begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            ST_GUARD: begin
                if (force_valid) begin
                    target_d = force_joy;
                end
                if (guard_cnt_q == GUARD_MAX) begin
                    state_d    = target_d ? ST_JOY : ST_MOUSE;
                    idle_cnt_d = '0;
                end else if (frame_tick) begin
                    guard_cnt_d = guard_cnt_q + GUARD_W'(1);
                end
            end
            default: begin
                state_d = ST_MOUSE;
            end
        endcase

        mode_d         = (state_d == ST_JOY) || ((state_d == ST_GUARD) && target_d);
        trigger_mode_d = mode_d;
`ifdef ZAPPER_ARB_RELEASE_EN
        release_ok_d     = (state_d == ST_JOY) && (((state_q == ST_JOY) && release_ok_q) || !joy_btn);
        analog_trigger_d = (state_d == ST_JOY) && joy_btn && release_ok_d;
`else
        analog_trigger_d = (state_d == ST_JOY) && joy_btn;
`endif
    end

    // State and output registers; reset resamples the mouse toggle so no packet is seen spuriously.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_MOUSE;
            target_q         <= 1'b0;
            idle_cnt_q       <= '0;
            guard_cnt_q      <= '0;
            mouse_tog_q      <= ps2_mouse[24];
            mode_q           <= 1'b0;
            trigger_mode_q   <= 1'b0;
            analog_trigger_q <= 1'b0;
            switch_pulse_q   <= 1'b0;
`ifdef ZAPPER_ARB_RELEASE_EN
            release_ok_q     <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            target_q         <= target_d;
            idle_cnt_q       <= idle_cnt_d;
            guard_cnt_q      <= guard_cnt_d;
            mouse_tog_q      <= mouse_tog_d;
            mode_q           <= mode_d;
            trigger_mode_q   <= trigger_mode_d;
            analog_trigger_q <= analog_trigger_d;
            switch_pulse_q   <= switch_pulse_d;
`ifdef ZAPPER_ARB_RELEASE_EN
            release_ok_q     <= release_ok_d;
`endif
        end
    end

    assign state          = state_q;
    assign mode           = mode_q;
    assign trigger_mode   = trigger_mode_q;
    assign analog_trigger = analog_trigger_q;
    assign switch_pulse   = switch_pulse_q;

endmodule

// File: tb/tb_zapper_input_arb.sv
// Testbench for zapper_input_arb: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_zapper_input_arb;

    localparam int DEADZONE     = 16;
    localparam int HOLD_FRAMES  = 60;
    localparam int GUARD_FRAMES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [24:0] ps2_mouse;
    logic [15:0] analog;
    logic        joy_btn;
    logic        frame_tick;
    logic [1:0]  force_src;
    logic        mode, trigger_mode, analog_trigger, switch_pulse;
    logic [1:0]  state;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  chk_en   = 1'b0;
    logic mouse_tog = 1'b0;

    // Behavioural model: 0 = mouse owns, 1 = stick owns, 2 = switching.
    int  m_state = 0, m_target = 0, m_idle = 0, m_guard = 0;
    int  m_pulse = 0, m_prev_tog = 0, m_prev_btn = 0, m_rel = 0;

    zapper_input_arb #(
        .DEADZONE(DEADZONE), .HOLD_FRAMES(HOLD_FRAMES), .GUARD_FRAMES(GUARD_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .ps2_mouse(ps2_mouse), .analog(analog),
        .joy_btn(joy_btn), .frame_tick(frame_tick), .force_src(force_src),
        .mode(mode), .trigger_mode(trigger_mode), .analog_trigger(analog_trigger),
        .state(state), .switch_pulse(switch_pulse)
    );

    always #5 clk = ~clk;

    function automatic int absVal(input logic [7:0] v);
        int s;
        s = int'($signed(v));
        return (s < 0) ? -s : s;
    endfunction

    // Advance the model by one clock edge using the inputs the DUT sees.
    always @(posedge clk) begin
        int  fsel, old_state;
        bit  m_act, j_act, own_act, oth_act;
        if (reset) begin
            m_state = 0; m_target = 0; m_idle = 0; m_guard = 0; m_pulse = 0; m_rel = 0;
        end else begin
            m_act = (int'(ps2_mouse[24]) != m_prev_tog) &&
                    (ps2_mouse[15:8] != 0 || ps2_mouse[23:16] != 0 || ps2_mouse[0]);
            j_act = absVal(analog[7:0]) > DEADZONE || absVal(analog[15:8]) > DEADZONE || joy_btn;
            fsel  = (force_src == 2'd1) ? 0 : (force_src == 2'd2) ? 1 : -1;
            old_state = m_state;
            m_pulse = 0;
            if (m_state != 2) begin
                own_act = (m_state == 0) ? m_act : j_act;
                oth_act = (m_state == 0) ? j_act : m_act;
                if (fsel >= 0 && fsel != m_state) begin
                    m_target = fsel; m_state = 2; m_guard = 0; m_pulse = 1;
                end else if (fsel < 0 && oth_act && !own_act && m_idle == HOLD_FRAMES) begin
                    m_target = 1 - m_state; m_state = 2; m_guard = 0; m_pulse = 1;
                end else if (own_act) begin
                    m_idle = 0;
                end else if (frame_tick && m_idle < HOLD_FRAMES) begin
                    m_idle++;
                end
            end else begin
                if (fsel >= 0) m_target = fsel;
                if (m_guard == GUARD_FRAMES) begin
                    m_state = m_target; m_idle = 0;
                end else if (frame_tick) begin
                    m_guard++;
                end
            end
            if (m_state == 1) m_rel = ((old_state == 1 && m_rel != 0) || !joy_btn) ? 1 : 0;
            else m_rel = 0;
        end
        m_prev_tog = int'(ps2_mouse[24]);
        m_prev_btn = int'(joy_btn);
    end

    // Compare the DUT against the model on every falling edge once reset has been applied.
    always @(negedge clk) begin
        logic [1:0] e_state;
        logic       e_mode, e_atrig, e_pulse;
        if (chk_en) begin
            e_state = 2'(m_state);
            e_mode  = (m_state == 1) || (m_state == 2 && m_target == 1);
`ifdef ZAPPER_ARB_RELEASE_EN
            e_atrig = (m_state == 1) && (m_prev_btn != 0) && (m_rel != 0);
`else
            e_atrig = (m_state == 1) && (m_prev_btn != 0);
`endif
            e_pulse = (m_pulse != 0);
            n_checks++;
            if (state === e_state && mode === e_mode && trigger_mode === e_mode &&
                analog_trigger === e_atrig && switch_pulse === e_pulse)
                n_pass++;
            else
                $display("[TB] FAIL model_cmp t=%0t: got st=%0d md=%0d tm=%0d at=%0d sp=%0d, expected st=%0d md=%0d tm=%0d at=%0d sp=%0d",
                         $time, state, mode, trigger_mode, analog_trigger, switch_pulse,
                         e_state, e_mode, e_mode, e_atrig, e_pulse);
        end
    end

    task automatic applyStimulus(input logic [7:0] ax, input logic [7:0] ay, input logic jbtn,
                                 input logic tick, input logic [1:0] fsrc, input logic mpkt,
                                 input logic [7:0] mx, input logic [7:0] my, input logic mbtn);
        if (mpkt) mouse_tog = ~mouse_tog;
        ps2_mouse  = {mouse_tog, my, mx, 7'd0, mbtn};
        analog     = {ay, ax};
        joy_btn    = jbtn;
        frame_tick = tick;
        force_src  = fsrc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleCycle(input logic tick);
        applyStimulus(8'd0, 8'd0, 1'b0, tick, 2'd0, 1'b0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic idleFrames(input int n);
        for (int i = 0; i < n; i++) begin
            idleCycle(1'b1);
            idleCycle(1'b0);
        end
    endtask

    task automatic checkOutput(input string name, input logic [1:0] es, input logic em,
                               input logic ea, input logic ep);
        n_checks++;
        if (state === es && mode === em && trigger_mode === em && analog_trigger === ea && switch_pulse === ep)
            n_pass++;
        else
            $display("[TB] FAIL %s: got st=%0d md=%0d tm=%0d at=%0d sp=%0d, expected st=%0d md=%0d tm=%0d at=%0d sp=%0d",
                     name, state, mode, trigger_mode, analog_trigger, switch_pulse, es, em, em, ea, ep);
    endtask

    task automatic checkModel(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("[TB] FAIL %s: model value %0d, expected %0d", name, got, exp);
    endtask

    initial begin
        int mrate, jrate, spread;
        logic [1:0] fsrc;
        logic [7:0] ax, ay;
        reset = 1'b1;
        idleCycle(1'b0);
        idleCycle(1'b0);
        reset = 1'b0;
        chk_en = 1'b1;
        checkOutput("reset_state", 2'd0, 1'b0, 1'b0, 1'b0);

        // Mouse packet with X=+5 keeps the mouse as owner.
        applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b1, 8'd5, 8'd0, 1'b0);
        checkOutput("mouse_pkt", 2'd0, 1'b0, 1'b0, 1'b0);
        checkModel("idle_after_pkt", m_idle, 0);

        // Simultaneous stick and mouse activity at full idle: owner wins.
        idleFrames(HOLD_FRAMES);
        checkModel("idle_saturated", m_idle, 60);
        applyStimulus(8'd40, 8'd0, 1'b0, 1'b0, 2'd0, 1'b1, 8'd3, 8'd0, 1'b0);
        checkOutput("simultaneous", 2'd0, 1'b0, 1'b0, 1'b0);
        checkModel("simul_idle", m_idle, 0);

        // Stick takes over after 60 idle frames.
        idleFrames(HOLD_FRAMES);
        applyStimulus(8'd40, 8'd0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("switch_enter", 2'd2, 1'b1, 1'b0, 1'b1);
        idleCycle(1'b0);
        checkOutput("pulse_once", 2'd2, 1'b1, 1'b0, 1'b0);
        idleCycle(1'b1);
        checkOutput("guard_frame1", 2'd2, 1'b1, 1'b0, 1'b0);
        idleCycle(1'b1);
        checkOutput("guard_frame2", 2'd2, 1'b1, 1'b0, 1'b0);
        idleCycle(1'b0);
        checkOutput("joy_owner", 2'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'd0, 8'd0, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("joy_trigger", 2'd1, 1'b1, 1'b1, 1'b0);

        // Forcing the mouse from JOY goes through GUARD with the trigger suppressed.
        applyStimulus(8'd0, 8'd0, 1'b1, 1'b0, 2'd1, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("force_guard", 2'd2, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'd0, 8'd0, 1'b1, 1'b1, 2'd1, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("force_frame1", 2'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'd0, 8'd0, 1'b1, 1'b1, 2'd1, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("force_frame2", 2'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'd0, 8'd0, 1'b1, 1'b0, 2'd1, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("force_mouse", 2'd0, 1'b0, 1'b0, 1'b0);

        // Deadzone boundary and the -128 magnitude case.
        idleFrames(HOLD_FRAMES);
        applyStimulus(8'd16, 8'd0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("deadzone_edge", 2'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h80, 8'd0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("neg128_switch", 2'd2, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of a switch returns to MOUSE.
        idleCycle(1'b1);
        reset = 1'b1;
        idleCycle(1'b0);
        reset = 1'b0;
        checkOutput("reset_mid_guard", 2'd0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with per-block activity rates.
        fsrc = 2'd0;
        for (int b = 0; b < 16; b++) begin
            mrate  = (b % 3 == 0) ? 4 : (b % 3 == 1) ? 80 : 1500;
            jrate  = (b % 2 == 0) ? 6 : 200;
            spread = (b % 4 == 0) ? 127 : 20;
            for (int c = 0; c < 400; c++) begin
                reset = ($urandom_range(0, 1999) == 0);
                if ($urandom_range(0, 59) == 0) begin
                    case ($urandom_range(0, 5))
                        1: fsrc = 2'd3;
                        2: fsrc = 2'd1;
                        3: fsrc = 2'd2;
                        default: fsrc = 2'd0;
                    endcase
                end
                ax = 8'(int'($urandom_range(0, 2 * spread)) - spread);
                ay = 8'(int'($urandom_range(0, 2 * spread)) - spread);
                applyStimulus(ax, ay, $urandom_range(0, jrate - 1) == 0,
                              $urandom_range(0, 3) == 0, fsrc,
                              $urandom_range(0, mrate - 1) == 0,
                              8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                              1'($urandom_range(0, 1)));
            end
        end
        reset = 1'b0;
        idleCycle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
